// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline boundary register and the
// stage wrappers built on top of it: stall-bus encoding, stage actions and
// the MEM/WB-style payload field layout used to pack/unpack in_data.
package pipe_stage_reg_pkg;

    // Stall bus encoding: a set bit stops the corresponding stage
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Core stall bus width (one bit per stage: PC, IF, ID, EX, MEM, WB)
    localparam int STALL_BUS_W = 6;

    // Payload field widths
    localparam int WD_W          = 5;
    localparam int WREG_W        = 1;
    localparam int WDATA_W       = 32;
    localparam int HI_W          = 32;
    localparam int LO_W          = 32;
    localparam int WHILO_W       = 1;
    localparam int LLBIT_WE_W    = 1;
    localparam int LLBIT_VALUE_W = 1;

    // Payload field offsets inside the concatenated word (LSB first)
    localparam int WD_LSB          = 0;
    localparam int WREG_LSB        = WD_LSB + WD_W;
    localparam int WDATA_LSB       = WREG_LSB + WREG_W;
    localparam int HI_LSB          = WDATA_LSB + WDATA_W;
    localparam int LO_LSB          = HI_LSB + HI_W;
    localparam int WHILO_LSB       = LO_LSB + LO_W;
    localparam int LLBIT_WE_LSB    = WHILO_LSB + WHILO_W;
    localparam int LLBIT_VALUE_LSB = LLBIT_WE_LSB + LLBIT_WE_W;
    localparam int PAYLOAD_W       = LLBIT_VALUE_LSB + LLBIT_VALUE_W;

    // Packed view of the full write-back payload, MSB field first
    typedef struct packed {
        logic [LLBIT_VALUE_W-1:0] llbit_value;
        logic [LLBIT_WE_W-1:0]    llbit_we;
        logic [WHILO_W-1:0]       whilo;
        logic [LO_W-1:0]          lo;
        logic [HI_W-1:0]          hi;
        logic [WDATA_W-1:0]       wdata;
        logic [WREG_W-1:0]        wreg;
        logic [WD_W-1:0]          wd;
    } payload_t;

    // What the boundary register does on a given edge
    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } stage_act_e;

    // Flush beats every stall combination; a stopped upstream feeding a
    // running downstream must inject a bubble, otherwise the word is held.
    function automatic stage_act_e decode_act(input logic flush,
                                              input logic s_up,
                                              input logic s_dn);
        stage_act_e act;
        if (flush)
            act = ACT_BUBBLE;
        else if (s_up == STOP && s_dn == NO_STOP)
            act = ACT_BUBBLE;
        else if (s_up == NO_STOP)
            act = ACT_PASS;
        else
            act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    // Next count: +1 unless already at the top of the range
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
        logic [CNT_W-1:0] nxt;
        if (cur == {CNT_W{1'b1}})
            nxt = cur;
        else
            nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        return nxt;
    endfunction

    // Count register: clear has priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= sat_inc(value);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: carries a payload word and a valid
// flag from stage STAGE to STAGE+1 under the core stall bus, with flush
// and saturating bubble/hold performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 STALL_W    = 6,
    parameter int                 STAGE      = 4,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    logic              s_up;
    logic              s_dn;
    stage_act_e        act_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              unused_stall;

    // Pick out the two stall bits that matter; the last stage has no
    // downstream stall and so always bubbles when its upstream stops.
    generate
        if (STAGE >= STALL_W || STAGE < 0) begin : g_bad_stage
            $fatal(1, "pipe_stage_reg: STAGE must be in 0..STALL_W-1");
        end else begin : g_stall_tap
            assign s_up = stall[STAGE];
            if (STAGE < STALL_W - 1) begin : g_has_dn
                assign s_dn = stall[STAGE+1];
            end else begin : g_last
                assign s_dn = NO_STOP;
            end
        end
    endgenerate

    // Other stages' stall bits are intentionally not consulted
    assign unused_stall = &{1'b0, stall};

    assign act_p0 = decode_act(flush, s_up, s_dn);

    // ---- stage boundary p0 -> p1: registered payload and valid ----
    // Load, bubble or keep the boundary contents according to the action
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= BUBBLE_VAL;
        end else begin
            case (act_p0)
                ACT_PASS: begin
                    vld_p1  <= in_valid;
                    data_p1 <= in_data;
                end
                ACT_BUBBLE: begin
                    vld_p1  <= 1'b0;
                    data_p1 <= BUBBLE_VAL;
                end
                default: begin
                    vld_p1  <= vld_p1;
                    data_p1 <= data_p1;
                end
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_p0 == ACT_BUBBLE),
        .clr   (cnt_clr),
        .value (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act_p0 == ACT_HOLD),
        .clr   (cnt_clr),
        .value (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (mid stage, last stage with a
// non-zero bubble value, narrow counters) share one stimulus stream.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int SW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          cnt_clr;

    logic          ov_a, ov_b, ov_c;
    logic [DW-1:0] od_a, od_b, od_c;
    logic [15:0]   bc_a, hc_a, bc_b, hc_b;
    logic [3:0]    bc_c, hc_c;

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(4), .BUBBLE_VAL(32'h0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_a), .out_data(od_a), .cnt_clr(cnt_clr), .bubble_cnt(bc_a), .hold_cnt(hc_a));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(5), .BUBBLE_VAL(32'h0BAD_0BAD), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_b), .out_data(od_b), .cnt_clr(cnt_clr), .bubble_cnt(bc_b), .hold_cnt(hc_b));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(4), .BUBBLE_VAL(32'h0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_c), .out_data(od_c), .cnt_clr(cnt_clr), .bubble_cnt(bc_c), .hold_cnt(hc_c));

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model: per instance its stage index, counter ceiling and bubble word
    int            m_stage [3] = '{4, 5, 4};
    int            m_max   [3] = '{65535, 65535, 15};
    logic [DW-1:0] m_bubval[3] = '{32'h0, 32'h0BAD_0BAD, 32'h0};
    logic          m_vld   [3];
    logic [DW-1:0] m_data  [3];
    int            m_bub   [3];
    int            m_hold  [3];

    // 0 = pass, 1 = bubble, 2 = hold
    function automatic int action(input int stg);
        logic up, dn;
        up = stall[stg];
        dn = (stg < SW - 1) ? stall[stg+1] : 1'b0;
        if (flush || (up && !dn)) return 1;
        if (!up) return 0;
        return 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_vld[i]  <= 1'b0;
                m_data[i] <= m_bubval[i];
                m_bub[i]  <= 0;
                m_hold[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (action(m_stage[i]))
                    0: begin m_vld[i] <= in_valid; m_data[i] <= in_data; end
                    1: begin m_vld[i] <= 1'b0;     m_data[i] <= m_bubval[i]; end
                    default: ;
                endcase
                m_bub[i]  <= cnt_clr ? 0 :
                             (action(m_stage[i]) == 1 && m_bub[i] < m_max[i]) ? m_bub[i] + 1 : m_bub[i];
                m_hold[i] <= cnt_clr ? 0 :
                             (action(m_stage[i]) == 2 && m_hold[i] < m_max[i]) ? m_hold[i] + 1 : m_hold[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("a_valid", {63'd0, ov_a}, {63'd0, m_vld[0]});
            chk("a_data",  {32'd0, od_a}, {32'd0, m_data[0]});
            chk("a_bub",   {48'd0, bc_a}, 64'(m_bub[0]));
            chk("a_hold",  {48'd0, hc_a}, 64'(m_hold[0]));
            chk("b_valid", {63'd0, ov_b}, {63'd0, m_vld[1]});
            chk("b_data",  {32'd0, od_b}, {32'd0, m_data[1]});
            chk("b_bub",   {48'd0, bc_b}, 64'(m_bub[1]));
            chk("b_hold",  {48'd0, hc_b}, 64'(m_hold[1]));
            chk("c_valid", {63'd0, ov_c}, {63'd0, m_vld[2]});
            chk("c_data",  {32'd0, od_c}, {32'd0, m_data[2]});
            chk("c_bub",   {60'd0, bc_c}, 64'(m_bub[2]));
            chk("c_hold",  {60'd0, hc_c}, 64'(m_hold[2]));
        end
    end

    task automatic cyc(input logic [SW-1:0] s, input logic f, input logic v,
                       input logic [DW-1:0] d, input logic c);
        stall = s; flush = f; in_valid = v; in_data = d; cnt_clr = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_a_valid", {63'd0, ov_a}, 64'd0);
        chk("rst_a_data",  {32'd0, od_a}, 64'd0);
        chk("rst_b_data",  {32'd0, od_b}, 64'h0BAD_0BAD);
        chk("rst_a_cnts",  {32'd0, bc_a, hc_a}, 64'd0);
        rst = 1'b1;
        cmp_on = 1'b1;

        cyc(6'b000000, 0, 1, 32'hDEAD_BEEF, 0);
        chk("pass_data",  {32'd0, od_a}, 64'hDEAD_BEEF);
        chk("pass_valid", {63'd0, ov_a}, 64'd1);
        chk("pass_cnts",  {32'd0, bc_a, hc_a}, 64'd0);
        chk("model_pass", {32'd0, m_data[0]}, 64'hDEAD_BEEF);

        cyc(6'b011111, 0, 1, 32'h1111_1111, 0);
        chk("bub_valid", {63'd0, ov_a}, 64'd0);
        chk("bub_data",  {32'd0, od_a}, 64'd0);
        chk("bub_cnt",   {48'd0, bc_a}, 64'd1);
        chk("last_pass", {32'd0, od_b}, 64'h1111_1111);

        repeat (3) cyc(6'b111111, 0, 1, 32'h2222_2222, 0);
        chk("hold_cnt3",   {48'd0, hc_a}, 64'd3);
        chk("hold_bub1",   {48'd0, bc_a}, 64'd1);
        chk("last_bub3",   {48'd0, bc_b}, 64'd3);
        chk("last_bubval", {32'd0, od_b}, 64'h0BAD_0BAD);
        chk("model_hold",  64'(m_hold[0]), 64'd3);

        cyc(6'b000000, 0, 1, 32'hCAFE_0001, 0);
        cyc(6'b110000, 0, 1, 32'h0000_0099, 0);
        chk("hold_data",  {32'd0, od_a}, 64'hCAFE_0001);
        chk("hold_valid", {63'd0, ov_a}, 64'd1);
        chk("hold_cnt4",  {48'd0, hc_a}, 64'd4);

        cyc(6'b110000, 1, 1, 32'h0000_0077, 0);
        chk("flush_valid", {63'd0, ov_a}, 64'd0);
        chk("flush_data",  {32'd0, od_a}, 64'd0);
        chk("flush_bub",   {48'd0, bc_a}, 64'd2);
        chk("flush_hold",  {48'd0, hc_a}, 64'd4);

        cyc(6'b100000, 0, 1, 32'h0000_0055, 0);
        chk("last_bub6", {48'd0, bc_b}, 64'd6);
        chk("ign_pass",  {32'd0, od_a}, 64'h55);

        cyc(6'b001111, 0, 0, 32'hA5A5_A5A5, 0);
        chk("inv_valid", {63'd0, ov_a}, 64'd0);
        chk("inv_data",  {32'd0, od_a}, 64'hA5A5_A5A5);

        repeat (20) cyc(6'b111111, 0, 1, 32'h0, 0);
        chk("sat_hold15", {60'd0, hc_c}, 64'd15);
        chk("wide_hold",  {48'd0, hc_a}, 64'd24);
        chk("last_bub26", {48'd0, bc_b}, 64'd26);

        cyc(6'b111111, 0, 1, 32'h0, 1);
        chk("clr_hold",  {60'd0, hc_c}, 64'd0);
        chk("clr_bub",   {60'd0, bc_c}, 64'd0);
        chk("clr_data",  {32'd0, od_a}, 64'hA5A5_A5A5);

        repeat (20) cyc(6'b011111, 0, 1, 32'h0, 0);
        chk("sat_bub15", {60'd0, bc_c}, 64'd15);
        chk("wide_bub",  {48'd0, bc_a}, 64'd20);

        cyc(6'b000000, 0, 1, 32'h1234_5678, 0);
        chk("pre_rst_data", {32'd0, od_a}, 64'h1234_5678);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", {63'd0, ov_a}, 64'd0);
        chk("arst_data",  {32'd0, od_a}, 64'd0);
        chk("arst_b",     {32'd0, od_b}, 64'h0BAD_0BAD);
        chk("arst_cnts",  {32'd0, bc_a, hc_a}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc(6'b000000, 0, 1, 32'hABCD_EF01, 0);
        chk("post_rst_data", {32'd0, od_a}, 64'hABCD_EF01);
        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
